// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder: 68000-style bus target serving a 4-word register window.
// Optional M68K_RESP_BERR_EN adds nBERR; index-0 writes then end in a bus error.
module m68k_bus_responder #(
    parameter logic [23:1] BASE_ADDR   = 23'h7FFFFC,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [15:0] ID_VALUE    = 16'hA516,
    parameter logic [15:0] REG_RESET   = 16'h0000
) (
    input  logic        CLK,
    input  logic        nRESET,
    input  logic        nAS,
    input  logic        nUDS,
    input  logic        nLDS,
    input  logic        RnW,
    input  logic [23:1] A,
    input  logic [15:0] D_IN,
    output logic [15:0] D_OUT,
    output logic        D_OE,
    output logic        nDTACK,
    output logic [47:0] CTRL_OUT,
    output logic        WR_STROBE,
    output logic [1:0]  WR_INDEX
`ifdef M68K_RESP_BERR_EN
    ,
    output logic        nBERR
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_MISS} state_t;

    logic [1:0]  as_q, uds_q, lds_q;
    logic        as_s, uds_s, lds_s;
    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [1:0]  idx_q, lane_q;
    logic        rnw_q;
    logic [15:0] reg1_q, reg2_q, reg3_q, dout_q;
    logic        dtack_q, oe_q, wstb_q;
    logic [1:0]  widx_q;
`ifdef M68K_RESP_BERR_EN
    logic        berr_q;
`endif

    logic        dec, hit, enter_ack, berr_hit;
    logic [1:0]  acc_idx, acc_lane;
    logic        acc_rnw;
    logic [15:0] rd_data;

    function automatic logic [15:0] merge(input logic [15:0] old,
                                          input logic [15:0] d,
                                          input logic [1:0]  ln);
        merge = {ln[1] ? d[15:8] : old[15:8],
                 ln[0] ? d[7:0]  : old[7:0]};
    endfunction

    // Two-flop synchronizers for the asynchronous bus strobes.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            as_q  <= 2'b11;
            uds_q <= 2'b11;
            lds_q <= 2'b11;
        end else begin
            as_q  <= {as_q[0], nAS};
            uds_q <= {uds_q[0], nUDS};
            lds_q <= {lds_q[0], nLDS};
        end
    end

    assign as_s  = as_q[1];
    assign uds_s = uds_q[1];
    assign lds_s = lds_q[1];

    assign dec = (state_q == S_IDLE) && !as_s && (!uds_s || !lds_s);
    assign hit = (A[23:3] == BASE_ADDR[23:3]);

    assign enter_ack = (dec && hit && (WAIT_STATES == 0))
                    || ((state_q == S_WAIT) && !as_s && (cnt_q <= 4'd1));

    // Access attributes: live bus at decode, latched copy while waiting.
    always_comb begin
        if (state_q == S_IDLE) begin
            acc_idx  = A[2:1];
            acc_rnw  = RnW;
            acc_lane = {~uds_s, ~lds_s};
        end else begin
            acc_idx  = idx_q;
            acc_rnw  = rnw_q;
            acc_lane = lane_q;
        end
    end

    // Read mux; index 0 is the fixed identification word.
    always_comb begin
        case (acc_idx)
            2'd1:    rd_data = reg1_q;
            2'd2:    rd_data = reg2_q;
            2'd3:    rd_data = reg3_q;
            default: rd_data = ID_VALUE;
        endcase
    end

`ifdef M68K_RESP_BERR_EN
    assign berr_hit = ~acc_rnw & (acc_idx == 2'd0);
`else
    assign berr_hit = 1'b0;
`endif

    // Bus cycle FSM with registered bus outputs and register file.
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= 2'd0;
            lane_q  <= 2'd0;
            rnw_q   <= 1'b1;
            reg1_q  <= REG_RESET;
            reg2_q  <= REG_RESET;
            reg3_q  <= REG_RESET;
            dout_q  <= 16'h0000;
            dtack_q <= 1'b1;
            oe_q    <= 1'b0;
            wstb_q  <= 1'b0;
            widx_q  <= 2'd0;
`ifdef M68K_RESP_BERR_EN
            berr_q  <= 1'b1;
`endif
        end else begin
            wstb_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (dec) begin
                        idx_q  <= A[2:1];
                        rnw_q  <= RnW;
                        lane_q <= {~uds_s, ~lds_s};
                        cnt_q  <= 4'(WAIT_STATES);
                        if (!hit) begin
                            state_q <= S_MISS;
                        end else if (WAIT_STATES == 0) begin
                            state_q <= S_ACK;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (as_s) begin
                        state_q <= S_IDLE;
                    end else if (cnt_q <= 4'd1) begin
                        state_q <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_ACK: begin
                    if (as_s) begin
                        state_q <= S_IDLE;
                        dtack_q <= 1'b1;
                        oe_q    <= 1'b0;
`ifdef M68K_RESP_BERR_EN
                        berr_q  <= 1'b1;
`endif
                    end
                end
                S_MISS: begin
                    if (as_s) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (enter_ack) begin
                if (berr_hit) begin
`ifdef M68K_RESP_BERR_EN
                    berr_q <= 1'b0;
`endif
                end else begin
                    dtack_q <= 1'b0;
                    if (acc_rnw) begin
                        dout_q <= rd_data;
                        oe_q   <= 1'b1;
                    end else begin
                        wstb_q <= 1'b1;
                        widx_q <= acc_idx;
                        case (acc_idx)
                            2'd1: reg1_q <= merge(reg1_q, D_IN, acc_lane);
                            2'd2: reg2_q <= merge(reg2_q, D_IN, acc_lane);
                            2'd3: reg3_q <= merge(reg3_q, D_IN, acc_lane);
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign D_OUT     = dout_q;
    assign D_OE      = oe_q;
    assign nDTACK    = dtack_q;
    assign CTRL_OUT  = {reg3_q, reg2_q, reg1_q};
    assign WR_STROBE = wstb_q;
    assign WR_INDEX  = widx_q;
`ifdef M68K_RESP_BERR_EN
    assign nBERR     = berr_q;
`endif

endmodule

// File: tb/tb_m68k_bus_responder.sv
// tb_m68k_bus_responder: directed bus cycles against a 2-wait and an 8-wait responder.
// Define M68K_RESP_BERR_EN to exercise the bus-error variant.
module tb_m68k_bus_responder;

    localparam logic [23:1] BASE = 23'h7FFFFC;
`ifdef M68K_RESP_BERR_EN
    localparam bit BERR = 1'b1;
`else
    localparam bit BERR = 1'b0;
`endif

    logic        clk;
    logic        nRESET;
    logic        nAS, nAS2, nUDS, nLDS, RnW;
    logic [23:1] A;
    logic [15:0] D_IN;

    logic [15:0] D_OUT, D_OUT2;
    logic        D_OE, D_OE2;
    logic        nDTACK, nDTACK2;
    logic [47:0] CTRL_OUT, CTRL_OUT2;
    logic        WR_STROBE, WR_STROBE2;
    logic [1:0]  WR_INDEX, WR_INDEX2;
`ifdef M68K_RESP_BERR_EN
    logic        nBERR, nBERR2;
`endif

    logic        ack_m, ack_s;

    int n_cmp = 0;
    int n_err = 0;
    int stb_m = 0;
    int stb_s = 0;

    int          t_lat, t_rel;
    logic [15:0] t_rd;
    logic        t_oe, t_dt, t_oe_rel;

    m68k_bus_responder #(.WAIT_STATES(2)) u_dut (
        .CLK(clk), .nRESET(nRESET), .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS),
        .RnW(RnW), .A(A), .D_IN(D_IN), .D_OUT(D_OUT), .D_OE(D_OE),
        .nDTACK(nDTACK), .CTRL_OUT(CTRL_OUT), .WR_STROBE(WR_STROBE),
        .WR_INDEX(WR_INDEX)
`ifdef M68K_RESP_BERR_EN
        , .nBERR(nBERR)
`endif
    );

    m68k_bus_responder #(.WAIT_STATES(8)) u_slow (
        .CLK(clk), .nRESET(nRESET), .nAS(nAS2), .nUDS(nUDS), .nLDS(nLDS),
        .RnW(RnW), .A(A), .D_IN(D_IN), .D_OUT(D_OUT2), .D_OE(D_OE2),
        .nDTACK(nDTACK2), .CTRL_OUT(CTRL_OUT2), .WR_STROBE(WR_STROBE2),
        .WR_INDEX(WR_INDEX2)
`ifdef M68K_RESP_BERR_EN
        , .nBERR(nBERR2)
`endif
    );

`ifdef M68K_RESP_BERR_EN
    assign ack_m = !nDTACK || !nBERR;
    assign ack_s = !nDTACK2 || !nBERR2;
`else
    assign ack_m = !nDTACK;
    assign ack_s = !nDTACK2;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (WR_STROBE === 1'b1) stb_m++;
        if (WR_STROBE2 === 1'b1) stb_s++;
    end

    task automatic check(input string tag, input logic [47:0] got,
                         input logic [47:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic slow, input logic [23:1] a,
                       input logic rnw, input logic [1:0] ln,
                       input logic [15:0] wd);
        logic ack;
        t_lat = 0; t_rel = 0; t_rd = 16'h0;
        t_oe = 1'b0; t_dt = 1'b1; t_oe_rel = 1'b1;
        @(negedge clk);
        A = a; RnW = rnw; D_IN = wd;
        nUDS = ~ln[1]; nLDS = ~ln[0];
        if (slow) nAS2 = 1'b0;
        else nAS = 1'b0;
        for (int i = 1; i <= 40 && t_lat == 0; i++) begin
            @(posedge clk); #1;
            ack = slow ? ack_s : ack_m;
            if (ack) begin
                t_lat = i;
                t_rd  = slow ? D_OUT2 : D_OUT;
                t_oe  = slow ? D_OE2 : D_OE;
                t_dt  = slow ? nDTACK2 : nDTACK;
            end
        end
        @(negedge clk);
        nAS = 1'b1; nAS2 = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
        for (int j = 1; j <= 10 && t_rel == 0; j++) begin
            @(posedge clk); #1;
            ack = slow ? ack_s : ack_m;
            if (!ack) begin
                t_rel    = j;
                t_oe_rel = slow ? D_OE2 : D_OE;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int s0;
        logic seen;
        nRESET = 1'b0;
        nAS = 1'b1; nAS2 = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
        RnW = 1'b1; A = '0; D_IN = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_dtack", 48'(nDTACK), 48'd1);
        check("rst_oe", 48'(D_OE), 48'd0);
        check("rst_dout", 48'(D_OUT), 48'd0);
        check("rst_stb", 48'(WR_STROBE), 48'd0);
        check("rst_widx", 48'(WR_INDEX), 48'd0);
        check("rst_ctrl", CTRL_OUT, 48'd0);
        check("rst_dtack2", 48'(nDTACK2), 48'd1);
`ifdef M68K_RESP_BERR_EN
        check("rst_berr", 48'(nBERR), 48'd1);
`endif
        @(negedge clk);
        nRESET = 1'b1;
        repeat (2) @(negedge clk);

        bus(1'b0, BASE, 1'b1, 2'b11, 16'h0);
        check("rd0_lat", 48'(t_lat), 48'd5);
        check("rd0_data", 48'(t_rd), 48'hA516);
        check("rd0_oe", 48'(t_oe), 48'd1);
        check("rd0_rel", 48'(t_rel), 48'd3);
        check("rd0_oe_rel", 48'(t_oe_rel), 48'd0);

        s0 = stb_m;
        bus(1'b0, BASE + 23'd1, 1'b0, 2'b11, 16'h1234);
        check("wr1_lat", 48'(t_lat), 48'd5);
        check("wr1_stb", 48'(stb_m - s0), 48'd1);
        check("wr1_widx", 48'(WR_INDEX), 48'd1);
        check("wr1_reg", 48'(CTRL_OUT[15:0]), 48'h1234);
        bus(1'b0, BASE + 23'd1, 1'b1, 2'b11, 16'h0);
        check("rd1_data", 48'(t_rd), 48'h1234);

        bus(1'b0, BASE + 23'd2, 1'b0, 2'b11, 16'h5566);
        bus(1'b0, BASE + 23'd2, 1'b0, 2'b10, 16'hAB00);
        check("wr2_upper", 48'(CTRL_OUT[31:16]), 48'hAB66);
        bus(1'b0, BASE + 23'd3, 1'b0, 2'b01, 16'h77CC);
        check("wr3_lower", 48'(CTRL_OUT[47:32]), 48'h00CC);
        check("wr3_widx", 48'(WR_INDEX), 48'd3);

        s0 = stb_m;
        bus(1'b0, 23'h7FFFF8, 1'b0, 2'b11, 16'hFFFF);
        check("miss_lat", 48'(t_lat), 48'd0);
        check("miss_stb", 48'(stb_m - s0), 48'd0);
        bus(1'b0, BASE + 23'd2, 1'b1, 2'b11, 16'h0);
        check("after_miss_lat", 48'(t_lat), 48'd5);
        check("after_miss_rd", 48'(t_rd), 48'hAB66);

        bus(1'b1, BASE, 1'b1, 2'b11, 16'h0);
        check("slow_lat", 48'(t_lat), 48'd11);
        check("slow_rd", 48'(t_rd), 48'hA516);

        s0 = stb_s;
        seen = 1'b0;
        @(negedge clk);
        A = BASE + 23'd1; RnW = 1'b0; D_IN = 16'hFFFF;
        nUDS = 1'b0; nLDS = 1'b0; nAS2 = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        nAS2 = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (nDTACK2 !== 1'b1) seen = 1'b1;
        end
        check("abort_dtack", 48'(seen), 48'd0);
        check("abort_stb", 48'(stb_s - s0), 48'd0);
        check("abort_regs", CTRL_OUT2, 48'd0);

        s0 = stb_m;
        bus(1'b0, BASE, 1'b0, 2'b11, 16'hDEAD);
        check("wr0_lat", 48'(t_lat), 48'd5);
        check("wr0_dtack", 48'(t_dt), BERR ? 48'd1 : 48'd0);
        check("wr0_stb", 48'(stb_m - s0), BERR ? 48'd0 : 48'd1);
        check("wr0_widx", 48'(WR_INDEX), BERR ? 48'd3 : 48'd0);
        check("wr0_rel", 48'(t_rel), 48'd3);
        check("wr0_regs", CTRL_OUT, 48'h00CC_AB66_1234);

        @(negedge clk);
        A = BASE + 23'd1; RnW = 1'b1;
        nUDS = 1'b0; nLDS = 1'b0; nAS = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_ack_pre", 48'(nDTACK), 48'd0);
        #2;
        nRESET = 1'b0;
        #1;
        check("rst_ack_dtack", 48'(nDTACK), 48'd1);
        check("rst_ack_oe", 48'(D_OE), 48'd0);
        check("rst_ack_dout", 48'(D_OUT), 48'd0);
        check("rst_ack_regs", CTRL_OUT, 48'd0);
        @(negedge clk);
        nAS = 1'b1; nUDS = 1'b1; nLDS = 1'b1;
        @(negedge clk);
        nRESET = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_dtack", 48'(nDTACK), 48'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
